// File: rtl/io_arb_pkg.sv
// Shared encodings and helpers for the io channel arbiter.
package io_arb_pkg;

  localparam int IO_DATA_W = 5;

  typedef enum logic [2:0] {
    I_IDLE  = 3'b001,
    I_GRANT = 3'b010,
    I_XFER  = 3'b100
  } in_state_t;

  typedef enum logic [2:0] {
    O_IDLE    = 3'b001,
    O_COLLECT = 3'b010,
    O_ACK     = 3'b100
  } out_state_t;

  // Width of an index into n sources; never narrower than one bit.
  function automatic int GRANT_W(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/io_rr_picker.sv
// Combinational round-robin picker: first set candidate strictly after ptr, wrapping.
module io_rr_picker
  import io_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int GW = GRANT_W(N)
) (
  input  logic [N-1:0]  cand,
  input  logic [GW-1:0] ptr,
  output logic [GW-1:0] idx,
  output logic          valid
);

  logic [GW-1:0] probe;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    probe = '0;
    for (int i = 1; i <= N; i++) begin
      probe = GW'((int'(ptr) + i) % N);
      if (!valid && cand[probe]) begin
        valid = 1'b1;
        idx   = probe;
      end
    end
  end

endmodule

// File: rtl/io_chan_arbiter.sv
// Shares the io unit's input channel round-robin among sources and broadcasts
// its output channel to all enabled sinks with a joined acknowledge.
module io_chan_arbiter
  import io_arb_pkg::*;
#(
  parameter int N_IN    = 2,
  parameter int N_OUT   = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      input_rdy_from_io,
  output logic                      input_val_to_io,
  output logic [IO_DATA_W-1:0]      input_data_to_io,
  input  logic [N_IN-1:0]           src_req_from_dev,
  input  logic [N_IN-1:0]           src_enable_from_pnl,
  output logic [N_IN-1:0]           src_rdy_to_dev,
  input  logic [N_IN-1:0]           src_val_from_dev,
  input  logic [IO_DATA_W*N_IN-1:0] src_data_from_dev,
  input  logic                      output_rdy_from_io,
  input  logic [IO_DATA_W-1:0]      output_data_from_io,
  output logic                      output_ack_to_io,
  input  logic [N_OUT-1:0]          sink_enable_from_pnl,
  output logic [N_OUT-1:0]          sink_rdy_to_dev,
  input  logic [N_OUT-1:0]          sink_ack_from_dev,
  output logic [IO_DATA_W-1:0]      sink_data_to_dev,
  output logic [2:0]                grant_idx_to_pnl,
  output logic                      in_busy_to_pnl,
  output logic                      out_busy_to_pnl,
  output logic                      timeout_to_pnl
);

  localparam int GW = GRANT_W(N_IN);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  in_state_t      i_state;
  out_state_t     o_state;
  logic [GW-1:0]  grant;
  logic [GW-1:0]  ptr;
  logic [GW-1:0]  pick_idx;
  logic           pick_valid;
  logic [TW-1:0]  timer;
  logic           timeout_hit;
  logic [N_IN-1:0] src_rdy_q;
  logic           timeout_q;

  logic [N_OUT-1:0]     mask;
  logic [N_OUT-1:0]     acked;
  logic [N_OUT-1:0]     acked_next;
  logic [IO_DATA_W-1:0] sink_data_q;
  logic                 ack_q;

  io_rr_picker #(.N(N_IN), .GW(GW)) u_picker (
    .cand  (src_req_from_dev & src_enable_from_pnl),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign timeout_hit = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));

  // Val has priority over abort and timeout; a timeout moves ptr past the silent source.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_state   <= I_IDLE;
      grant     <= '0;
      ptr       <= '0;
      timer     <= '0;
      src_rdy_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (i_state)
        I_IDLE: begin
          if (input_rdy_from_io && pick_valid) begin
            grant               <= pick_idx;
            timer               <= '0;
            src_rdy_q           <= '0;
            src_rdy_q[pick_idx] <= 1'b1;
            i_state             <= I_GRANT;
          end
        end
        I_GRANT: begin
          if (src_val_from_dev[grant]) begin
            ptr       <= grant;
            src_rdy_q <= '0;
            i_state   <= I_XFER;
          end else if (!input_rdy_from_io || !src_enable_from_pnl[grant]) begin
            src_rdy_q <= '0;
            i_state   <= I_IDLE;
          end else if (timeout_hit) begin
            ptr       <= grant;
            src_rdy_q <= '0;
            timeout_q <= 1'b1;
            i_state   <= I_IDLE;
          end else if (timer != '1) begin
            timer <= timer + TW'(1);
          end
        end
        I_XFER: begin
          if (!src_val_from_dev[grant]) i_state <= I_IDLE;
        end
        default: i_state <= I_IDLE;
      endcase
    end
  end

  assign acked_next = acked | (sink_ack_from_dev & mask);

  // Mask is frozen per character, so enable changes only apply to the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_state     <= O_IDLE;
      mask        <= '0;
      acked       <= '0;
      sink_data_q <= '0;
      ack_q       <= 1'b0;
    end else begin
      case (o_state)
        O_IDLE: begin
          if (output_rdy_from_io) begin
            sink_data_q <= output_data_from_io;
            mask        <= sink_enable_from_pnl;
            acked       <= '0;
            o_state     <= O_COLLECT;
          end
        end
        O_COLLECT: begin
          acked <= acked_next;
          if (acked_next == mask) begin
            ack_q   <= 1'b1;
            o_state <= O_ACK;
          end
        end
        O_ACK: begin
          if (!output_rdy_from_io && (sink_ack_from_dev & mask) == '0) begin
            ack_q   <= 1'b0;
            o_state <= O_IDLE;
          end
        end
        default: o_state <= O_IDLE;
      endcase
    end
  end

  assign input_val_to_io  = (i_state != I_IDLE) ? src_val_from_dev[grant] : 1'b0;
  assign input_data_to_io = (i_state != I_IDLE)
                            ? src_data_from_dev[int'(grant)*IO_DATA_W +: IO_DATA_W] : '0;
  assign src_rdy_to_dev   = src_rdy_q;
  assign timeout_to_pnl   = timeout_q;
  assign grant_idx_to_pnl = 3'(grant);
  assign in_busy_to_pnl   = (i_state != I_IDLE);

  assign sink_rdy_to_dev  = (o_state == O_COLLECT) ? (mask & ~acked) : '0;
  assign sink_data_to_dev = sink_data_q;
  assign output_ack_to_io = ack_q;
  assign out_busy_to_pnl  = (o_state != O_IDLE);

endmodule

// File: doc/io_chan_arbiter.md
Name: io_chan_arbiter

Overview:
- Shares the io unit's single 5-bit input channel (rdy/val) and output channel (rdy/ack) among several peripherals, e.g. tape reader and panel keyboard on input, printer and tape punch on output.
- Input side: grants one requesting source per character, round-robin, with a no-response timeout.
- Output side: broadcasts each character to all enabled sinks and acknowledges the io unit only after every enabled sink has acked.
- Sits between io_unit and the device pins.

Parameters:
- N_IN, 2, number of input sources (1..8).
- N_OUT, 2, number of output sinks (1..8).
- TIMEOUT, 1023, cycles a granted source may hold off val before the grant is revoked; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- input_rdy_from_io  in  1  io unit ready for an input character.
- input_val_to_io  out  1  granted source's val.
- input_data_to_io  out  5  granted source's data.
- src_req_from_dev  in  N_IN  level, source holds a character.
- src_enable_from_pnl  in  N_IN  level, source enabled.
- src_rdy_to_dev  out  N_IN  one-hot ready to the granted source.
- src_val_from_dev  in  N_IN  source val.
- src_data_from_dev  in  5*N_IN  source data; source i occupies [5i+4:5i].
- output_rdy_from_io  in  1  io unit presents an output character.
- output_data_from_io  in  5  output character.
- output_ack_to_io  out  1  joined ack to the io unit.
- sink_enable_from_pnl  in  N_OUT  level, sink enabled.
- sink_rdy_to_dev  out  N_OUT  per-sink ready.
- sink_ack_from_dev  in  N_OUT  per-sink ack.
- sink_data_to_dev  out  5  registered output character.
- grant_idx_to_pnl  out  3  current or last granted source.
- in_busy_to_pnl  out  1  input FSM not idle.
- out_busy_to_pnl  out  1  output FSM not idle.
- timeout_to_pnl  out  1  one-cycle pulse on timeout.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. All registers clear on reset.
- Outputs at reset: all 0, input FSM I_IDLE, output FSM O_IDLE, round-robin pointer 0.

Input FSM:
- I_IDLE:
  - On input_rdy_from_io and a non-empty candidate set (req & enable), latch grant = first candidate at or after ptr+1, wrapping modulo N_IN.
  - Go to I_GRANT and clear the timer.
  - Latency from io rdy to src_rdy is 1 cycle.
- I_GRANT:
  - src_rdy_to_dev[grant] = 1 (registered, one-hot).
  - input_val_to_io and input_data_to_io are combinationally muxed from the granted source, and are 0 in I_IDLE.
  - On src_val_from_dev[grant]: go to I_XFER and set ptr = grant.
  - If input_rdy_from_io falls, or enable[grant] falls, before val: go to I_IDLE, ptr unchanged, no pulse.
  - If the timer reaches TIMEOUT (TIMEOUT≠0): go to I_IDLE, set ptr = grant (skips this source next time), pulse timeout_to_pnl.
  - If val and timeout occur in the same cycle, val wins.
- I_XFER:
  - src_rdy low; val and data still muxed from grant.
  - When val falls: go to I_IDLE.
  - Disabling the source here does not abort the transfer. No timeout applies.
- Data is mux-only; the io unit latches it on rdy & val.

Output FSM:
- O_IDLE:
  - On output_rdy_from_io: latch sink_data_to_dev <= output_data_from_io, latch mask <= sink_enable_from_pnl, clear the acked vector, go to O_COLLECT.
- O_COLLECT:
  - sink_rdy_to_dev = mask & ~acked.
  - acked |= sink_ack_from_dev & mask (sticky).
  - When acked == mask: go to O_ACK and set output_ack_to_io = 1.
  - If mask == 0, go to O_ACK on the next cycle (data discarded, io unit never stalls).
- O_ACK:
  - ack held high.
  - When output_rdy_from_io == 0 and (sink_ack_from_dev & mask) == 0: ack <= 0, go to O_IDLE.
- Enable changes take effect only at the next character.
- An ack from a disabled or already-acked sink is ignored.

Independence and busy flags:
- The input and output FSMs are independent; simultaneous activity is legal.
- in_busy_to_pnl = !I_IDLE; out_busy_to_pnl = !O_IDLE.

Timer:
- Width clog2(TIMEOUT+1); saturates, never wraps.

Reset mid-transfer:
- All rdy/val/ack outputs drop asynchronously. Devices must return to idle handshake.

Decomposition:
- Package io_arb_pkg holds:
  - I_IDLE/I_GRANT/I_XFER and O_IDLE/O_COLLECT/O_ACK encodings (one-hot, matching io_unit style);
  - IO_DATA_W = 5;
  - the GRANT_W helper.
- One sub-module, io_rr_picker: combinational; takes candidate vector and ptr, returns next index and a valid flag. Instantiated once for the input side.

Test Plan:
- Both sources enabled, both req=1, io rdy asserted 4× with val handshakes → grants 1,0,1,0; input_data_to_io = source data (e.g. 5'h13, 5'h05); ptr wraps.
- Source 0 granted, never raises val, TIMEOUT=8 → src_rdy[0] high for exactly 8 cycles, timeout_to_pnl pulses once, next grant goes to source 1.
- Sink mask 2'b11, sink0 acks at cycle 3, sink1 at cycle 7 → sink_rdy[0] drops after cycle 3, output_ack_to_io rises only after cycle 7, sink_data_to_dev = 5'b00110 throughout.
- All sinks disabled, io presents 12 characters → each acked with no sink_rdy activity; out_busy returns to 0 after each.
- Source disabled during I_GRANT → returns to I_IDLE, no pulse, ptr unchanged. Source disabled during I_XFER → transfer completes.
- Reset asserted mid-O_COLLECT and mid-I_XFER → all outputs 0 immediately, both FSMs idle, next transfer is normal.
